bus_sequencer: RTL

// Micro-sequencer for the shared 16-bit register bus of the matrix-multiply processor. Drives the bus source select
// (read_sel, codes 1..17) and one-hot destination write enables to run fetch/decode/execute over 8-bit instructions
// in IR. Sits between the instruction register and the bus mux; the only block allowed to drive read_sel.

---
 rtl/bus_pkg.sv | 60 ++++++
 rtl/mem_wait_counter.sv | 36 +++
 rtl/bus_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the matrix-multiply processor register bus.
// Contents: bus source codes (shared with the bus mux), write-enable bit
// indices, instruction class encodings, ALU op codes, sequencer state encoding
// and a source-legality helper.
package bus_pkg;

    localparam int WE_W_DEF = 6;

    // Bus source codes; 0 means the bus is driven to zero.
    localparam logic [4:0] SRC_NONE = 5'd0;
    localparam logic [4:0] SRC_IM   = 5'd1;
    localparam logic [4:0] SRC_DM   = 5'd2;
    localparam logic [4:0] SRC_PC   = 5'd4;
    localparam logic [4:0] SRC_ALU  = 5'd13;
    localparam logic [4:0] SRC_AC   = 5'd17;
    localparam logic [4:0] SRC_MAX  = SRC_AC;

    // Destination write-enable bit positions.
    localparam int WE_AR   = 0;
    localparam int WE_IR   = 1;
    localparam int WE_PC   = 2;
    localparam int WE_AC   = 3;
    localparam int WE_R    = 4;
    localparam int WE_ALUB = 5;

    typedef enum logic [2:0] {
        CLS_NOP = 3'b000,
        CLS_LDA = 3'b001,
        CLS_MVR = 3'b010,
        CLS_ADD = 3'b011,
        CLS_JZ  = 3'b100,
        CLS_LDM = 3'b101,
        CLS_ILL = 3'b110,
        CLS_HLT = 3'b111
    } cls_t;

    typedef enum logic [1:0] {
        ALU_PASS = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SUB  = 2'b10
    } alu_op_t;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_F_ADDR = 4'd1,
        ST_F_WAIT = 4'd2,
        ST_F_LOAD = 4'd3,
        ST_DECODE = 4'd4,
        ST_X1     = 4'd5,
        ST_X_WAIT = 4'd6,
        ST_X2     = 4'd7,
        ST_HALT   = 4'd8,
        ST_ERR    = 4'd9
    } state_t;

    function automatic logic src_legal(input logic [4:0] src);
        return (src != SRC_NONE) && (src <= SRC_MAX);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Memory-latency wait counter.
// Loads a latency value when an address register write happens, then counts
// down to zero and holds there (never wraps).
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-high reset (count -> 0)
//   load      in   load load_val this cycle (has priority over dec)
//   dec       in   decrement by one if not already zero
//   load_val  in   value to load
//   count     out  current count
//   zero      out  count == 0
module mem_wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bus_sequencer.sv
// Micro-sequencer for the shared 16-bit register bus. Runs fetch/decode/execute
// over 8-bit instructions held in IR by driving the bus source select and
// one-hot destination write enables. Sole driver of read_sel.
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   start     in   begin fetching (honoured only in IDLE/HALT/ERR)
//   ir        in   IR contents: [7:5] class, [4:0] bus source code
//   z_flag    in   ALU zero flag (sampled in DECODE)
//   read_sel  out  bus source select (0 = bus drives 0)
//   we        out  one-hot destination write enables
//   pc_inc    out  PC increment strobe
//   alu_op    out  ALU operation, valid with we[ALU_B]
//   busy      out  high outside IDLE/HALT/ERR
//   halted    out  high in HALT
//   err       out  high in ERR
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for start
// F_ADDR  | PC -> AR, wait counter loaded
// F_WAIT  | instruction memory latency
// F_LOAD  | IM -> IR, PC increment
// DECODE  | ir and z_flag sampled, no strobes
// X1      | first execute cycle (LDA/MVR/ADD/JZ/LDM)
// X_WAIT  | data memory latency after LDM address write
// X2      | second execute cycle (ADD result or LDM data -> AC)
// HALT    | HLT executed, waiting for start
// ERR     | illegal class or source, waiting for start
module bus_sequencer
    import bus_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int WE_W    = WE_W_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [7:0]      ir,
    input  logic            z_flag,
    output logic [4:0]      read_sel,
    output logic [WE_W-1:0] we,
    output logic            pc_inc,
    output logic [1:0]      alu_op,
    output logic            busy,
    output logic            halted,
    output logic            err
);

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t state, state_nx;
    cls_t   cls_q;
    cls_t   ir_cls;
    logic [4:0] ir_src;

    logic            cnt_load, cnt_dec, cnt_zero;
    logic [3:0]      cnt;
    logic            wait_last;

    logic [4:0]      read_sel_nx;
    logic [WE_W-1:0] we_nx;
    logic            pc_inc_nx;
    alu_op_t         alu_op_nx;
    logic            busy_nx, halted_nx, err_nx;

    assign ir_cls = cls_t'(ir[7:5]);
    assign ir_src = ir[4:0];

    mem_wait_counter #(.CNT_W(4)) u_wait (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (LAT),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // A wait state is entered with count = MEM_LAT >= 1; the cycle seen
    // with count 1 is the last one.
    assign wait_last = cnt_zero || (cnt == 4'd1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cls_q <= CLS_NOP;
        end else begin
            state <= state_nx;
            if (state == ST_DECODE) begin
                cls_q <= ir_cls;
            end
        end
    end

    // Next-state logic plus decode of the outputs belonging to the state
    // being entered; these are registered so every output is glitch-free
    // and valid for the entire cycle of its state.
    always_comb begin
        state_nx    = state;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        read_sel_nx = SRC_NONE;
        we_nx       = '0;
        pc_inc_nx   = 1'b0;
        alu_op_nx   = ALU_PASS;

        case (state)
            ST_IDLE, ST_HALT, ST_ERR: begin
                if (start) state_nx = ST_F_ADDR;
            end
            ST_F_ADDR: begin
                cnt_load = 1'b1;
                state_nx = (LAT == 4'd0) ? ST_F_LOAD : ST_F_WAIT;
            end
            ST_F_WAIT: begin
                cnt_dec = 1'b1;
                if (wait_last) state_nx = ST_F_LOAD;
            end
            ST_F_LOAD: begin
                state_nx = ST_DECODE;
            end
            ST_DECODE: begin
                case (ir_cls)
                    CLS_NOP: state_nx = ST_F_ADDR;
                    CLS_ILL: state_nx = ST_ERR;
                    CLS_HLT: state_nx = ST_HALT;
                    default: state_nx = src_legal(ir_src) ? ST_X1 : ST_ERR;
                endcase
            end
            ST_X1: begin
                case (cls_q)
                    CLS_ADD: state_nx = ST_X2;
                    CLS_LDM: begin
                        cnt_load = 1'b1;
                        state_nx = (LAT == 4'd0) ? ST_X2 : ST_X_WAIT;
                    end
                    default: state_nx = ST_F_ADDR;
                endcase
            end
            ST_X_WAIT: begin
                cnt_dec = 1'b1;
                if (wait_last) state_nx = ST_X2;
            end
            ST_X2: begin
                state_nx = ST_F_ADDR;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        case (state_nx)
            ST_F_ADDR: begin
                read_sel_nx  = SRC_PC;
                we_nx[WE_AR] = 1'b1;
            end
            ST_F_LOAD: begin
                read_sel_nx  = SRC_IM;
                we_nx[WE_IR] = 1'b1;
                pc_inc_nx    = 1'b1;
            end
            ST_X1: begin
                // X1 is only ever entered from DECODE, so ir and z_flag
                // are the values being sampled right now.
                case (ir_cls)
                    CLS_LDA: begin
                        read_sel_nx  = ir_src;
                        we_nx[WE_AC] = 1'b1;
                    end
                    CLS_MVR: begin
                        read_sel_nx = ir_src;
                        we_nx[WE_R] = 1'b1;
                    end
                    CLS_ADD: begin
                        read_sel_nx    = ir_src;
                        we_nx[WE_ALUB] = 1'b1;
                        alu_op_nx      = ALU_ADD;
                    end
                    CLS_JZ: begin
                        if (z_flag) begin
                            read_sel_nx  = ir_src;
                            we_nx[WE_PC] = 1'b1;
                        end
                    end
                    CLS_LDM: begin
                        read_sel_nx  = ir_src;
                        we_nx[WE_AR] = 1'b1;
                    end
                    default: begin
                        read_sel_nx = SRC_NONE;
                    end
                endcase
            end
            ST_X2: begin
                read_sel_nx  = (cls_q == CLS_ADD) ? SRC_ALU : SRC_DM;
                we_nx[WE_AC] = 1'b1;
            end
            default: begin
                read_sel_nx = SRC_NONE;
            end
        endcase
    end

    assign busy_nx   = !((state_nx == ST_IDLE) || (state_nx == ST_HALT) || (state_nx == ST_ERR));
    assign halted_nx = (state_nx == ST_HALT);
    assign err_nx    = (state_nx == ST_ERR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_sel <= '0;
            we       <= '0;
            pc_inc   <= 1'b0;
            alu_op   <= 2'b00;
            busy     <= 1'b0;
            halted   <= 1'b0;
            err      <= 1'b0;
        end else begin
            read_sel <= read_sel_nx;
            we       <= we_nx;
            pc_inc   <= pc_inc_nx;
            alu_op   <= alu_op_nx;
            busy     <= busy_nx;
            halted   <= halted_nx;
            err      <= err_nx;
        end
    end

endmodule
